wb_gpio_irq: RTL and testbench
==============================

// Module: wb_gpio_irq
// PURPOSE
//  Wishbone-slave GPIO controller inside main_partition, directly downstream of the MGMT SoC Wishbone port.
//  Drives the pad output and output-enable vectors, samples pad inputs through a 2-flop synchroniser,
//  and raises a level interrupt on per-pin programmable rising/falling edges.
//  Consumes wbs_* from the wrapper; produces io_out/io_oeb and one user_irq line.
// PARAMETERS
//  NB_GPIO   32           number of GPIO pins handled (1..32); register bits >= NB_GPIO read 0, writes ignored
//  ADR_BASE  32'h3000_0000 base address; block selected when wbs_adr_i[31:8] == ADR_BASE[31:8]
// PORTS
//  wb_clk_i    in   1        sole clock, rising edge
//  wb_rst_i    in   1        reset, asynchronous, active-high
//  wbs_cyc_i   in   1        Wishbone cycle
//  wbs_stb_i   in   1        Wishbone strobe
//  wbs_we_i    in   1        1 = write, 0 = read
//  wbs_sel_i   in   4        byte lane enables (writes only)
//  wbs_adr_i   in   32       byte address; register index = wbs_adr_i[4:2]
//  wbs_dat_i   in   32       write data
//  wbs_ack_o   out  1        transfer acknowledge
//  wbs_dat_o   out  32       read data, valid while wbs_ack_o = 1
//  gpio_in     in   NB_GPIO  asynchronous pad inputs
//  gpio_out    out  NB_GPIO  pad output values (= DATA_OUT register)
//  gpio_oeb    out  NB_GPIO  pad output enables, active-low (= OEB register)
//  irq         out  1        level interrupt = |(IRQ_STATUS & IRQ_EN), registered
// BEHAVIOUR
//  Register map (offset, access, reset):
//   0x00 DATA_OUT   RW   0
//   0x04 OEB        RW   all 1 (all pins inputs)
//   0x08 DATA_IN    RO   synchronised gpio_in (sync stage 2)
//   0x0C IRQ_EN     RW   0
//   0x10 IRQ_TYPE   RW   0 ; bit=0 rising edge, bit=1 falling edge
//   0x14 IRQ_STATUS W1C  0 ; write 1 clears bit, write 0 no effect
//   0x18..0x1C      unmapped: read 0, writes ignored, still acked
//  Handshake: req = cyc & stb & addr hit & ~ack; ack registered, asserted exactly 1 cycle after req is seen,
//   held 1 cycle, then low for >=1 cycle (max one transfer per 2 clocks). No wait states, no error.
//   Address miss -> no ack, wbs_dat_o = 0. cyc/stb dropped before ack -> transfer aborted, no register update.
//  Write: applied on the same edge ack rises; only lanes with wbs_sel_i[k]=1 update bits [8k+7:8k].
//  Read: wbs_dat_o registered with ack; 0 whenever ack = 0.
//  Input path: sync1 <= gpio_in; sync2 <= sync1; prev <= sync2. rise = sync2 & ~prev; fall = ~sync2 & prev.
//   Event bit i = IRQ_TYPE[i] ? fall[i] : rise[i]; sets IRQ_STATUS[i] on next edge regardless of IRQ_EN.
//   Pad edge -> IRQ_STATUS set within 3 clock edges; irq asserts 1 edge later (4 max).
//  Simultaneous event and W1C on same bit: set wins (bit stays 1).
//  IRQ_EN masks irq only, not status capture. Changing IRQ_TYPE does not clear pending status.
//  Reset (any time, incl. mid-transfer): all registers to reset values, sync1/sync2/prev = 0, ack = 0,
//   irq = 0. First cycle after reset with gpio_in high: a rising event on those pins IS captured (prev = 0).
//  Outputs at reset: wbs_ack_o 0, wbs_dat_o 0, gpio_out 0, gpio_oeb all 1, irq 0.
// TESTING
//  1 Reset: assert wb_rst_i async mid-write -> ack 0, gpio_oeb 32'hFFFF_FFFF, gpio_out 0, irq 0, no write applied.
//  2 Write 0x00 = 32'hA5A5_5A5A sel=4'b0101 -> gpio_out = 32'h00A5_005A; ack 1 cycle after req, width 1.
//  3 Drive gpio_in[3] 0->1 with IRQ_EN=0x8, IRQ_TYPE=0 -> IRQ_STATUS=0x8 within 3 edges, irq=1 next edge;
//     read 0x08 -> bit3 = 1.
//  4 IRQ_TYPE[5]=1, toggle gpio_in[5] 1->0 -> status bit5 set; rising edge on pin5 -> no set.
//  5 W1C 0x14 = 0x8 on the same cycle a new pin3 event is captured -> status bit3 remains 1, irq stays 1.
//  6 Read 0x18 and address outside ADR_BASE -> 0x18 acks with data 0; out-of-range gets no ack, no state change.

Source files
------------

// File: rtl/wb_gpio_irq.sv
// Wishbone-slave GPIO controller: pad output/enable registers, synchronised inputs,
// per-pin rising/falling edge capture into a W1C status register with a masked level irq.
module wb_gpio_irq #(
    parameter int unsigned NB_GPIO  = 32,
    parameter logic [31:0] ADR_BASE = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [NB_GPIO-1:0] gpio_in,
    output logic [NB_GPIO-1:0] gpio_out,
    output logic [NB_GPIO-1:0] gpio_oeb,
    output logic               irq
);

    typedef enum logic [2:0] {
        REG_DATA_OUT   = 3'd0,
        REG_OEB        = 3'd1,
        REG_DATA_IN    = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_IRQ_TYPE   = 3'd4,
        REG_IRQ_STATUS = 3'd5
    } reg_idx_e;

    // Registers are kept 32 bits wide; bits at or above NB_GPIO are forced to zero.
    localparam logic [31:0] PIN_MASK = (NB_GPIO >= 32) ? '1 : ((32'd1 << NB_GPIO) - 32'd1);

    logic [31:0] data_out_q, data_out_d;
    logic [31:0] oeb_q, oeb_d;
    logic [31:0] irq_en_q, irq_en_d;
    logic [31:0] irq_type_q, irq_type_d;
    logic [31:0] irq_status_q, irq_status_d;
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;
    logic [31:0] prev_q, prev_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    logic        hit, req, wr;
    logic [2:0]  idx;
    logic [31:0] lane_mask, wdata_m, gpio_in_ext, rise, fall, evt, rdata;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

    always_comb begin
        hit       = (wbs_adr_i[31:8] == ADR_BASE[31:8]);
        req       = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
        wr        = req & wbs_we_i;
        idx       = wbs_adr_i[4:2];
        lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        wdata_m   = wbs_dat_i & lane_mask;

        gpio_in_ext = '0;
        gpio_in_ext[NB_GPIO-1:0] = gpio_in;

        rise = sync2_q & ~prev_q;
        fall = ~sync2_q & prev_q;
        evt  = (irq_type_q & fall) | (~irq_type_q & rise);

        data_out_d   = data_out_q;
        oeb_d        = oeb_q;
        irq_en_d     = irq_en_q;
        irq_type_d   = irq_type_q;
        irq_status_d = irq_status_q;
        sync1_d      = gpio_in_ext & PIN_MASK;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;

        if (wr) begin
            case (idx)
                REG_DATA_OUT:   data_out_d   = ((data_out_q & ~lane_mask) | wdata_m) & PIN_MASK;
                REG_OEB:        oeb_d        = ((oeb_q & ~lane_mask) | wdata_m) & PIN_MASK;
                REG_IRQ_EN:     irq_en_d     = ((irq_en_q & ~lane_mask) | wdata_m) & PIN_MASK;
                REG_IRQ_TYPE:   irq_type_d   = ((irq_type_q & ~lane_mask) | wdata_m) & PIN_MASK;
                REG_IRQ_STATUS: irq_status_d = irq_status_q & ~wdata_m;
                default: ;
            endcase
        end
        // Event set is applied after the W1C clear so a coincident event wins.
        irq_status_d = (irq_status_d | evt) & PIN_MASK;

        case (idx)
            REG_DATA_OUT:   rdata = data_out_q;
            REG_OEB:        rdata = oeb_q;
            REG_DATA_IN:    rdata = sync2_q;
            REG_IRQ_EN:     rdata = irq_en_q;
            REG_IRQ_TYPE:   rdata = irq_type_q;
            REG_IRQ_STATUS: rdata = irq_status_q;
            default:        rdata = '0;
        endcase

        ack_d = req;
        dat_d = (req & ~wbs_we_i) ? rdata : '0;
        irq_d = |(irq_status_q & irq_en_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            data_out_q   <= '0;
            oeb_q        <= PIN_MASK;
            irq_en_q     <= '0;
            irq_type_q   <= '0;
            irq_status_q <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            oeb_q        <= oeb_d;
            irq_en_q     <= irq_en_d;
            irq_type_q   <= irq_type_d;
            irq_status_q <= irq_status_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            irq_q        <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = data_out_q[NB_GPIO-1:0];
    assign gpio_oeb  = oeb_q[NB_GPIO-1:0];
    assign irq       = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: register access, ack timing, edge capture,
// W1C/event collision, unmapped and out-of-range addressing, reset behaviour.
module tb_wb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, dat_i = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out, gpio_oeb;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [31:0] BASE = 32'h3000_0000;

    wb_gpio_irq #(.NB_GPIO(32), .ADR_BASE(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns the number of edges until ack (0 if no ack within the bound).
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int n, output logic [31:0] rd);
        n  = 0;
        rd = '0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                n  = i;
                rd = dat_o;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic [31:0] rd;
        wb_xfer(1'b1, BASE + off, d, s, n, rd);
        chk(tag, 32'(n), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        int n;
        logic [31:0] rd;
        wb_xfer(1'b0, BASE + off, '0, '0, n, rd);
        chk({tag, "_ack"}, 32'(n), 32'd1);
        chk(tag, rd, exp);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] rd;

        // 1: reset values, then reset asserted in the middle of a write
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_oeb", gpio_oeb, 32'hFFFF_FFFF);
        chk("rst_out", gpio_out, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; dat_i = 32'h0; sel = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("midrst_ack_async", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_oeb", gpio_oeb, 32'hFFFF_FFFF);
        chk("midrst_out", gpio_out, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        idle(2);
        chk("midrst_nowrite_oeb", gpio_oeb, 32'hFFFF_FFFF);
        rd_chk("rd_oeb_reset", 32'h04, 32'hFFFF_FFFF);

        // 2: byte-lane write, ack latency and width (strobe held past ack)
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_i = 32'hA5A5_5A5A; sel = 4'b0101;
        @(posedge clk); #1;
        chk("w0_ack_rise", {31'd0, ack}, 32'd1);
        chk("w0_gpio_out", gpio_out, 32'h00A5_005A);
        @(posedge clk); #1;
        chk("w0_ack_width", {31'd0, ack}, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        idle(1);
        rd_chk("rd_data_out", 32'h00, 32'h00A5_005A);

        // 3: rising edge on pin 3
        wr("w_irq_en", 32'h0C, 32'h0000_0008, 4'hF);
        wr("w_irq_type0", 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (irq) begin
                n = i;
                break;
            end
        end
        chk("pin3_irq_edges", 32'(n), 32'd4);
        rd_chk("rd_status_pin3", 32'h14, 32'h0000_0008);
        rd_chk("rd_data_in_pin3", 32'h08, 32'h0000_0008);

        // 4: falling-edge type on pin 5; its rising edge must not set status
        wr("w_irq_type5", 32'h10, 32'h0000_0020, 4'hF);
        @(negedge clk); gpio_in[5] = 1'b1;
        idle(5);
        rd_chk("rd_status_pin5_rise", 32'h14, 32'h0000_0008);
        @(negedge clk); gpio_in[5] = 1'b0;
        idle(5);
        rd_chk("rd_status_pin5_fall", 32'h14, 32'h0000_0028);
        chk("irq_masked_bit5", {31'd0, irq}, 32'd1);

        // 5: W1C on bit 3 in the same cycle a new pin 3 rising event is captured
        @(negedge clk); gpio_in[3] = 1'b0;
        idle(5);
        rd_chk("rd_status_pre_collide", 32'h14, 32'h0000_0028);
        @(negedge clk); gpio_in[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr("w1c_collide", 32'h14, 32'h0000_0008, 4'hF);
        idle(2);
        chk("collide_irq", {31'd0, irq}, 32'd1);
        rd_chk("rd_status_collide", 32'h14, 32'h0000_0028);
        wr("w1c_sel_masked", 32'h14, 32'h0000_0028, 4'b1110);
        rd_chk("rd_status_sel_masked", 32'h14, 32'h0000_0028);
        wr("w1c_all", 32'h14, 32'h0000_0028, 4'hF);
        idle(2);
        rd_chk("rd_status_cleared", 32'h14, 32'h0);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // 6: unmapped offset and out-of-range address
        rd_chk("rd_unmapped_18", 32'h18, 32'h0);
        wr("w_unmapped_1c", 32'h1C, 32'hFFFF_FFFF, 4'hF);
        wb_xfer(1'b1, 32'h3000_0100, 32'h0, 4'hF, n, rd);
        chk("miss_no_ack", 32'(n), 32'd0);
        chk("miss_dat_o", dat_o, 32'd0);
        chk("miss_gpio_out", gpio_out, 32'h00A5_005A);
        wb_xfer(1'b0, 32'h4000_0000, 32'h0, 4'h0, n, rd);
        chk("miss_rd_no_ack", 32'(n), 32'd0);
        rd_chk("rd_data_out_after_miss", 32'h00, 32'h00A5_005A);

        // Aborted transfer: strobe dropped before any edge sees it
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_i = 32'h0; sel = 4'hF;
        #2 stb = 1'b0; cyc = 1'b0;
        idle(2);
        chk("abort_gpio_out", gpio_out, 32'h00A5_005A);

        // Reset with pins already high: first cycle after reset captures a rising event
        @(negedge clk);
        gpio_in[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("post_rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rd_status_post_rst", 32'h14, 32'h0000_0009);
        rd_chk("rd_data_out_post_rst", 32'h00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
